motor_ramp_controller: RTL and testbench

Parametrised N-channel stepper motor controller driving dual H-bridge enables and coil lines, one channel per motor. Each channel takes a signed speed command (direction bit plus step period) and ramps its actual step period toward the target one tick per step. Direction reversals and stops go through a controlled deceleration to the slowest rate. It replaces the fixed two-motor controller under `top`, and adds a shared step prescaler, acceleration limiting and per-channel position counters.

---
 rtl/motor_pkg.sv | 30 +++
 rtl/motor_channel.sv | 127 ++++++++++++
 rtl/motor_ramp_controller.sv | 51 +++++
 tb/tb_motor_ramp_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared channel state type and coil excitation tables for the stepper ramp controller.
// Define MOTOR_HALFSTEP_EN to drive the 8-entry half-step sequence instead of full-step.
package motor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      BRAKE
   } chan_state_t;

   // Packed so that index 0 is the least significant nibble.
   localparam logic [3:0][3:0] FULL_SEQ = {4'b1001, 4'b1010, 4'b0110, 4'b0101};
   localparam logic [7:0][3:0] HALF_SEQ = {4'b1001, 4'b1000, 4'b1010, 4'b0010,
                                           4'b0110, 4'b0100, 4'b0101, 4'b0001};

`ifdef MOTOR_HALFSTEP_EN
   localparam int PHASE_W = 3;
`else
   localparam int PHASE_W = 2;
`endif

   function automatic logic [3:0] coil_of(input logic [PHASE_W-1:0] phase);
`ifdef MOTOR_HALFSTEP_EN
      return HALF_SEQ[phase];
`else
      return FULL_SEQ[phase];
`endif
   endfunction

endpackage

// File: rtl/motor_channel.sv
// One stepper channel: target latch, IDLE/RUN/BRAKE ramp FSM, phase and position tracking.
// Phase width and coil table follow MOTOR_HALFSTEP_EN through motor_pkg.
module motor_channel
   import motor_pkg::*;
#(
   parameter int PERIOD_W = 7,
   parameter int POS_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic                cmd_valid,
   input  logic                cmd_sign,
   input  logic [PERIOD_W-1:0] cmd_period,
   output logic [1:0]          enable,
   output logic [3:0]          coil,
   output logic                at_speed,
   output logic [POS_W-1:0]    position
);

   localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
   localparam logic [PERIOD_W-1:0] P_ONE      = PERIOD_W'(1);
   localparam logic [POS_W-1:0]    POS_ONE    = POS_W'(1);
   localparam logic [PHASE_W-1:0]  PH_ONE     = PHASE_W'(1);

   chan_state_t         state, state_n;
   logic                tgt_sign, tgt_sign_n, dir, dir_n;
   logic [PERIOD_W-1:0] tgt_period, tgt_period_n, cur, cur_n, step_cnt, step_cnt_n;
   logic [PHASE_W-1:0]  phase, phase_n;
   logic [POS_W-1:0]    position_n;
   logic                step, leave;

   function automatic logic [PERIOD_W-1:0] ramp_to(input logic [PERIOD_W-1:0] c,
                                                   input logic [PERIOD_W-1:0] t);
      if (c > t) return c - P_ONE;
      if (c < t) return c + P_ONE;
      return c;
   endfunction

   assign step  = tick && (state != IDLE) && (step_cnt == cur - P_ONE);
   assign leave = (tgt_period == '0) || (tgt_sign != dir);

   always_comb begin
      tgt_sign_n   = cmd_valid ? cmd_sign : tgt_sign;
      tgt_period_n = cmd_valid ? cmd_period : tgt_period;
      state_n      = state;
      dir_n        = dir;
      cur_n        = cur;
      step_cnt_n   = step_cnt;
      phase_n      = phase;
      position_n   = position;
      if (tick && state != IDLE)
         step_cnt_n = step ? '0 : step_cnt + P_ONE;
      case (state)
         IDLE: begin
            if (tgt_period != '0) begin
               state_n    = RUN;
               dir_n      = tgt_sign;
               cur_n      = PERIOD_MAX;
               step_cnt_n = '0;
            end
         end
         RUN: begin
            // A step coinciding with the decision to brake already slows down.
            if (leave) begin
               state_n = BRAKE;
               if (step && cur != PERIOD_MAX) cur_n = cur + P_ONE;
            end else if (step) begin
               cur_n = ramp_to(cur, tgt_period);
            end
         end
         BRAKE: begin
            if (!leave) begin
               state_n = RUN;
               if (step) cur_n = ramp_to(cur, tgt_period);
            end else if (step) begin
               if (cur == PERIOD_MAX) begin
                  if (tgt_period == '0) begin
                     state_n = IDLE;
                  end else begin
                     state_n = RUN;
                     dir_n   = tgt_sign;
                  end
               end else begin
                  cur_n = cur + P_ONE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      // Uses dir_n so the reversing step already moves the new way.
      if (step) begin
         phase_n    = dir_n ? phase - PH_ONE : phase + PH_ONE;
         position_n = dir_n ? position - POS_ONE : position + POS_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         tgt_sign   <= 1'b0;
         tgt_period <= '0;
         dir        <= 1'b0;
         cur        <= PERIOD_MAX;
         step_cnt   <= '0;
         phase      <= '0;
         position   <= '0;
         enable     <= 2'b00;
         coil       <= 4'b0000;
         at_speed   <= 1'b1;
      end else begin
         state      <= state_n;
         tgt_sign   <= tgt_sign_n;
         tgt_period <= tgt_period_n;
         dir        <= dir_n;
         cur        <= cur_n;
         step_cnt   <= step_cnt_n;
         phase      <= phase_n;
         position   <= position_n;
         enable     <= (state_n != IDLE) ? 2'b11 : 2'b00;
         coil       <= (state_n != IDLE) ? coil_of(phase_n) : 4'b0000;
         at_speed   <= ((state_n == RUN) && (cur_n == tgt_period_n)) ||
                       ((state_n == IDLE) && (tgt_period_n == '0));
      end
   end

endmodule

// File: rtl/motor_ramp_controller.sv
// N-channel stepper ramp controller: shared step prescaler feeding one motor_channel per motor.
// Step mode is chosen at build time by MOTOR_HALFSTEP_EN (see motor_pkg).
module motor_ramp_controller #(
   parameter int NUM_MOTORS = 2,
   parameter int PERIOD_W   = 7,
   parameter int PRESCALE   = 50,
   parameter int POS_W      = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_MOTORS-1:0]          cmd_valid,
   input  logic [NUM_MOTORS-1:0]          cmd_sign,
   input  logic [NUM_MOTORS*PERIOD_W-1:0] cmd_period,
   output logic [NUM_MOTORS*2-1:0]        enable,
   output logic [NUM_MOTORS*4-1:0]        coil,
   output logic [NUM_MOTORS-1:0]          at_speed,
   output logic [NUM_MOTORS*POS_W-1:0]    position
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] ps_cnt;
   logic            tick;

   assign tick = (ps_cnt == PS_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ps_cnt <= '0;
      else       ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
   end

   for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_chan
      motor_channel #(
         .PERIOD_W (PERIOD_W),
         .POS_W    (POS_W)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .tick       (tick),
         .cmd_valid  (cmd_valid[i]),
         .cmd_sign   (cmd_sign[i]),
         .cmd_period (cmd_period[i*PERIOD_W +: PERIOD_W]),
         .enable     (enable[i*2 +: 2]),
         .coil       (coil[i*4 +: 4]),
         .at_speed   (at_speed[i]),
         .position   (position[i*POS_W +: POS_W])
      );
   end

endmodule

// File: tb/tb_motor_ramp_controller.sv
// Bench for motor_ramp_controller: 2 channels, 4-bit period, prescale 2, 4-bit position, full-step.
module tb_motor_ramp_controller;

   localparam int NM   = 2;
   localparam int PW   = 4;
   localparam int PS   = 2;
   localparam int POSW = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] cmd_valid = '0;
   logic [1:0] cmd_sign = '0;
   logic [7:0] cmd_period = '0;
   logic [3:0] enable;
   logic [7:0] coil;
   logic [1:0] at_speed;
   logic [7:0] position;
   logic [21:0] obs;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   motor_ramp_controller #(
      .NUM_MOTORS (NM),
      .PERIOD_W   (PW),
      .PRESCALE   (PS),
      .POS_W      (POSW)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_sign   (cmd_sign),
      .cmd_period (cmd_period),
      .enable     (enable),
      .coil       (coil),
      .at_speed   (at_speed),
      .position   (position)
   );

   assign obs = {enable, coil, at_speed, position};

   // Reference model: countdown to next step, signed heading, phase taken from position.
   bit m_active [2];
   bit m_braking [2];
   bit m_ts [2];
   int m_tp [2];
   int m_rate [2];
   int m_head [2];
   int m_left [2];
   int m_pos [2];
   int m_edge;
   bit m_tick, m_want, m_nbrake;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NM; c++) begin
            m_active[c] = 0; m_braking[c] = 0; m_ts[c] = 0; m_tp[c] = 0;
            m_rate[c] = 15; m_head[c] = 1; m_left[c] = 0; m_pos[c] = 0;
         end
         m_edge = 0;
      end else begin
         m_tick = (m_edge % PS) == PS - 1;
         m_edge++;
         for (int c = 0; c < NM; c++) begin
            if (!m_active[c]) begin
               if (m_tp[c] != 0) begin
                  m_active[c] = 1; m_braking[c] = 0;
                  m_head[c] = m_ts[c] ? -1 : 1;
                  m_rate[c] = 15; m_left[c] = 15;
               end
            end else begin
               m_want = (m_tp[c] != 0) && (m_head[c] == (m_ts[c] ? -1 : 1));
               m_nbrake = !m_want;
               if (m_tick && m_left[c] == 1) begin
                  if (m_braking[c] && !m_want && m_rate[c] == 15) begin
                     if (m_tp[c] == 0) m_active[c] = 0;
                     else begin m_head[c] = -m_head[c]; m_nbrake = 0; end
                  end else if (m_want) begin
                     if (m_rate[c] > m_tp[c]) m_rate[c]--;
                     else if (m_rate[c] < m_tp[c]) m_rate[c]++;
                  end else if (m_rate[c] < 15) m_rate[c]++;
                  m_pos[c] = (m_pos[c] + m_head[c]) & 15;
                  m_left[c] = m_rate[c];
               end else if (m_tick) m_left[c]--;
               m_braking[c] = m_nbrake;
            end
            if (cmd_valid[c]) begin
               m_tp[c] = int'(cmd_period[c*4 +: 4]);
               m_ts[c] = cmd_sign[c];
            end
         end
      end
   end

   function automatic logic [21:0] model_out();
      logic [3:0] seq [4];
      logic [3:0] en;
      logic [7:0] co;
      logic [1:0] as;
      logic [7:0] po;
      seq = '{4'b0101, 4'b0110, 4'b1010, 4'b1001};
      for (int c = 0; c < NM; c++) begin
         en[c*2 +: 2] = m_active[c] ? 2'b11 : 2'b00;
         co[c*4 +: 4] = m_active[c] ? seq[m_pos[c] % 4] : 4'b0000;
         as[c] = (m_active[c] && !m_braking[c] && m_rate[c] == m_tp[c]) ||
                 (!m_active[c] && m_tp[c] == 0);
         po[c*4 +: 4] = 4'(m_pos[c]);
      end
      return {en, co, as, po};
   endfunction

   task automatic test_reset();
      reset = 1'b1; cmd_valid = '0; cmd_sign = '0; cmd_period = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({enable, coil, at_speed, position} !== {4'h0, 8'h00, 2'b11, 8'h00}) begin
         n_errors++;
         $display("FAIL reset_hold: got %h required %h", obs, {4'h0, 8'h00, 2'b11, 8'h00});
      end
      reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin
            n_errors++;
            $display("FAIL reset_release: got %h required %h", obs, model_out());
         end
      end
   endtask

   task automatic test_ch0_start();
      int exp_gap [4] = '{28, 26, 24, 24};
      logic [3:0] exp_coil [3] = '{4'b0110, 4'b1010, 4'b1001};
      int t_step [$];
      logic [3:0] prev;
      int cyc = 0;
      cmd_valid = 2'b01; cmd_sign[0] = 1'b0; cmd_period[3:0] = 4'd12;
      @(negedge clk);
      cmd_valid = '0;
      @(negedge clk);
      n_checks++;
      if (enable[1:0] !== 2'b11) begin
         n_errors++;
         $display("FAIL start_enable: got %b required 11", enable[1:0]);
      end
      prev = position[3:0];
      while (t_step.size() < 5 && cyc < 400) begin
         @(negedge clk); cyc++;
         n_checks++;
         if (obs !== model_out()) begin
            n_errors++;
            $display("FAIL start_model cyc %0d: got %h required %h", cyc, obs, model_out());
         end
         if (position[3:0] !== prev) begin
            if (t_step.size() < 3) begin
               n_checks++;
               if ({coil[3:0], position[3:0]} !== {exp_coil[t_step.size()], 4'(t_step.size() + 1)}) begin
                  n_errors++;
                  $display("FAIL start_step%0d: got coil %b pos %0d required coil %b pos %0d", t_step.size() + 1,
                           coil[3:0], position[3:0], exp_coil[t_step.size()], t_step.size() + 1);
               end
            end
            t_step.push_back(cyc);
            prev = position[3:0];
         end
      end
      n_checks++;
      if (t_step.size() != 5) begin
         n_errors++;
         $display("FAIL start_timeout: got %0d steps required 5", t_step.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (t_step[k+1] - t_step[k] != exp_gap[k]) begin
               n_errors++;
               $display("FAIL start_gap%0d: got %0d required %0d", k, t_step[k+1] - t_step[k], exp_gap[k]);
            end
         end
      end
   endtask

   task automatic test_reverse();
      int exp_gap [8] = '{24, 26, 28, 30, 30, 28, 26, 24};
      int exp_d [8] = '{1, 1, 1, -1, -1, -1, -1, -1};
      int gaps [$];
      int deltas [$];
      logic [3:0] prev;
      int cyc = 0, last = 0, d;
      prev = position[3:0];
      while (position[3:0] === prev && cyc < 100) begin
         @(negedge clk); cyc++;
      end
      cmd_valid = 2'b01; cmd_sign[0] = 1'b1; cmd_period[3:0] = 4'd12;
      prev = position[3:0]; cyc = 0;
      while (gaps.size() < 8 && cyc < 600) begin
         @(negedge clk); cyc++;
         cmd_valid = '0;
         n_checks++;
         if (obs !== model_out()) begin
            n_errors++;
            $display("FAIL reverse_model cyc %0d: got %h required %h", cyc, obs, model_out());
         end
         if (position[3:0] !== prev) begin
            d = int'(4'(position[3:0] - prev));
            deltas.push_back(d == 15 ? -1 : d);
            gaps.push_back(cyc - last);
            last = cyc;
            prev = position[3:0];
         end
      end
      n_checks++;
      if (gaps.size() != 8) begin
         n_errors++;
         $display("FAIL reverse_timeout: got %0d steps required 8", gaps.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (gaps[k] != exp_gap[k] || deltas[k] != exp_d[k]) begin
               n_errors++;
               $display("FAIL reverse_step%0d: got gap %0d delta %0d required gap %0d delta %0d",
                        k, gaps[k], deltas[k], exp_gap[k], exp_d[k]);
            end
         end
      end
   endtask

   task automatic test_stop();
      logic [3:0] held;
      int cyc = 0;
      cmd_valid = 2'b01; cmd_sign[0] = 1'b0; cmd_period[3:0] = 4'd0;
      do begin
         @(negedge clk); cyc++;
         cmd_valid = '0;
         n_checks++;
         if (obs !== model_out()) begin
            n_errors++;
            $display("FAIL stop_model cyc %0d: got %h required %h", cyc, obs, model_out());
         end
      end while (enable[1:0] !== 2'b00 && cyc < 1000);
      held = position[3:0];
      repeat (60) begin
         @(negedge clk);
         n_checks++;
         if ({enable[1:0], coil[3:0], at_speed[0], position[3:0]} !== {2'b00, 4'b0000, 1'b1, held}) begin
            n_errors++;
            $display("FAIL stop_idle: got en %b coil %b as %b pos %0d required 00 0000 1 %0d",
                     enable[1:0], coil[3:0], at_speed[0], position[3:0], held);
         end
      end
   endtask

   task automatic test_ch1_wrap();
      logic [3:0] prev;
      int steps = 0, cyc = 0;
      cmd_valid = 2'b10; cmd_sign[1] = 1'b0; cmd_period[7:4] = 4'($urandom_range(1, 15));
      prev = position[7:4];
      while (steps < 16 && cyc < 1500) begin
         @(negedge clk); cyc++;
         cmd_valid = '0;
         n_checks++;
         if (obs !== model_out() || {enable[1:0], coil[3:0]} !== 6'b0) begin
            n_errors++;
            $display("FAIL wrap_model cyc %0d: got %h required %h", cyc, obs, model_out());
         end
         if (position[7:4] !== prev) begin
            steps++;
            n_checks++;
            if (position[7:4] !== 4'(steps)) begin
               n_errors++;
               $display("FAIL wrap_pos: got %0d required %0d", position[7:4], 4'(steps));
            end
            prev = position[7:4];
         end
      end
      n_checks++;
      if (steps != 16) begin
         n_errors++;
         $display("FAIL wrap_timeout: got %0d steps required 16", steps);
      end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin
            n_errors++;
            $display("FAIL random_model cyc %0d: got %h required %h", cyc, obs, model_out());
         end
         cmd_valid = '0;
         for (int c = 0; c < NM; c++) begin
            if ($urandom_range(0, 39) == 0) begin
               cmd_valid[c] = 1'b1;
               cmd_sign[c] = 1'($urandom_range(0, 1));
               cmd_period[c*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            end
         end
      end
      @(negedge clk);
      cmd_valid = '0;
   endtask

   task automatic test_reset_midrun();
      int cyc = 0;
      cmd_valid = 2'b11;
      cmd_sign = 2'($urandom_range(0, 3));
      cmd_period = {4'($urandom_range(2, 15)), 4'($urandom_range(2, 15))};
      do begin
         @(negedge clk); cyc++;
         cmd_valid = '0;
         n_checks++;
         if (obs !== model_out()) begin
            n_errors++;
            $display("FAIL midrun_model cyc %0d: got %h required %h", cyc, obs, model_out());
         end
      end while (!(enable === 4'hF && cyc > 60) && cyc < 200);
      n_checks++;
      if (enable !== 4'hF) begin
         n_errors++;
         $display("FAIL midrun_running: got en %b required 1111", enable);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({enable, coil, at_speed, position} !== {4'h0, 8'h00, 2'b11, 8'h00}) begin
         n_errors++;
         $display("FAIL midrun_async: got %h required %h", obs, {4'h0, 8'h00, 2'b11, 8'h00});
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (150) begin
         @(negedge clk);
         n_checks++;
         if (obs !== model_out() || {enable, coil, position} !== 20'h0) begin
            n_errors++;
            $display("FAIL midrun_after: got %h required %h", obs, model_out());
         end
      end
   endtask

   initial begin
      test_reset();
      test_ch0_start();
      test_reverse();
      test_stop();
      test_ch1_wrap();
      test_random();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
